// File: rtl/ffn_hidden_1_pkg.sv
// Shared encoder definitions: Q8.8 sample format, sequence length, FSM states
// and the ReLU/saturate helper used by the feed-forward stages.
package ffn_hidden_1_pkg;

    localparam int DATA_W  = 16;
    localparam int FRAC    = 8;
    localparam int SEQ_LEN = 30;
    localparam int ACC_W   = 40;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_MAC,
        ST_NEXT,
        ST_DONE
    } state_t;

    // Clamp an already-rescaled Q8.8 value to [0, 0x7FFF].
    function automatic logic [DATA_W-1:0] q88_relu_sat(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W-1:0] q_max;
        q_max = $signed({{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}});
        if (v < 0)
            q88_relu_sat = '0;
        else if (v > q_max)
            q88_relu_sat = {1'b0, {(DATA_W-1){1'b1}}};
        else
            q88_relu_sat = v[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/ffn_hidden_1_mac_unit.sv
// Dot-product accumulator for one hidden unit: products, bias alignment,
// rescale, ReLU/saturate and the registered output strobe.
module ffn_mac_unit
    import ffn_hidden_1_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_first,
    input  logic                     i_acc_en,
    input  logic                     i_bias_en,
    input  logic signed [DATA_W-1:0] i_x,
    input  logic signed [DATA_W-1:0] i_w,
    output logic [DATA_W-1:0]        o_data,
    output logic                     o_valid
);

    logic signed [2*DATA_W-1:0] w_prod;
    logic signed [ACC_W-1:0]    w_prod_ext;
    logic signed [ACC_W-1:0]    w_bias_ext;
    logic signed [ACC_W-1:0]    w_base;
    logic signed [ACC_W-1:0]    w_sum;
    logic signed [ACC_W-1:0]    w_shift;
    logic signed [ACC_W-1:0]    r_acc;
    logic [DATA_W-1:0]          r_data;
    logic                       r_valid;

    assign w_prod     = i_x * i_w;
    assign w_prod_ext = ACC_W'(w_prod);
    // Bias is Q8.8 while products are Q16.16, so align it before adding.
    assign w_bias_ext = ACC_W'(i_w) <<< FRAC;
    assign w_base     = i_first ? '0 : r_acc;
    assign w_sum      = w_base + (i_bias_en ? w_bias_ext : w_prod_ext);
    assign w_shift    = w_sum >>> FRAC;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= i_bias_en;
            if (i_acc_en)
                r_acc <= w_sum;
            if (i_bias_en)
                r_data <= q88_relu_sat(w_shift);
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;

endmodule

// File: rtl/ffn_hidden_1.sv
// First feed-forward stage: buffers one token, streams D_HID dot products
// against an external weight ROM and emits ReLU'd Q8.8 activations serially.
module ffn_hidden_1
    import ffn_hidden_1_pkg::*;
#(
    parameter int D_MODEL = 4,
    parameter int D_HID   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     data_in,
    input  logic                  data_in_valid,
    output logic                  data_in_ready,
    input  logic [2:0]            block_sel,
    output logic [3+((D_HID > 1) ? $clog2(D_HID) : 1)+$clog2(D_MODEL+1)-1:0] w_addr,
    input  logic [DATA_W-1:0]     w_data,
    output logic [DATA_W-1:0]     data_out,
    output logic                  data_out_valid,
    output logic                  done
);

    localparam int HW = (D_HID > 1) ? $clog2(D_HID) : 1;
    localparam int KW = $clog2(D_MODEL + 1);
    localparam int EW = (D_MODEL > 1) ? $clog2(D_MODEL) : 1;
    localparam int CW = $clog2(D_MODEL + 3);
    localparam int TW = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
    localparam int AW = 3 + HW + KW;

    state_t                   r_state;
    logic [TW-1:0]            r_tok;
    logic [EW-1:0]            r_elem;
    logic [HW-1:0]            r_h;
    logic [CW-1:0]            r_kc;
    logic [2:0]               r_bsq;
    logic [AW-1:0]            r_w_addr;
    logic                     r_done;
    logic signed [DATA_W-1:0] r_x [D_MODEL];

    logic                     w_accept;
    logic                     w_mac;
    logic                     w_first;
    logic                     w_acc_en;
    logic                     w_bias_en;
    logic signed [DATA_W-1:0] w_x;

    assign data_in_ready = (r_state == ST_IDLE) || (r_state == ST_LOAD);
    assign w_accept      = data_in_valid && data_in_ready;

    // r_kc is the cycle within a unit: ROM data for k arrives at r_kc == k+1,
    // the bias at D_MODEL+1, and D_MODEL+2 is the drain cycle after the last unit.
    assign w_mac     = (r_state == ST_MAC);
    assign w_first   = w_mac && (r_kc == CW'(1));
    assign w_acc_en  = w_mac && (r_kc >= CW'(1)) && (r_kc <= CW'(D_MODEL));
    assign w_bias_en = w_mac && (r_kc == CW'(D_MODEL + 1));

    always_comb begin
        w_x = '0;
        for (int i = 0; i < D_MODEL; i++)
            if (r_kc == CW'(i + 1))
                w_x = r_x[i];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_tok    <= '0;
            r_elem   <= '0;
            r_h      <= '0;
            r_kc     <= '0;
            r_bsq    <= '0;
            r_w_addr <= '0;
            r_done   <= 1'b0;
            for (int i = 0; i < D_MODEL; i++)
                r_x[i] <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_x[0] <= data_in;
                        if (r_tok == '0)
                            r_bsq <= block_sel;
                        r_elem  <= EW'(1);
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (w_accept) begin
                        for (int i = 0; i < D_MODEL; i++)
                            if (r_elem == EW'(i))
                                r_x[i] <= data_in;
                        if (r_elem == EW'(D_MODEL - 1)) begin
                            r_state  <= ST_MAC;
                            r_h      <= '0;
                            r_kc     <= '0;
                            r_w_addr <= {r_bsq, HW'(0), KW'(0)};
                        end else begin
                            r_elem <= r_elem + EW'(1);
                        end
                    end
                end
                ST_MAC: begin
                    if (r_kc < CW'(D_MODEL)) begin
                        r_kc     <= r_kc + CW'(1);
                        r_w_addr <= {r_bsq, r_h, KW'(r_kc + CW'(1))};
                    end else if (r_kc == CW'(D_MODEL + 1)) begin
                        if (r_h == HW'(D_HID - 1)) begin
                            r_kc <= CW'(D_MODEL + 2);
                        end else begin
                            r_h      <= r_h + HW'(1);
                            r_kc     <= '0;
                            r_w_addr <= {r_bsq, r_h + HW'(1), KW'(0)};
                        end
                    end else if (r_kc == CW'(D_MODEL + 2)) begin
                        r_state <= ST_NEXT;
                    end else begin
                        r_kc <= r_kc + CW'(1);
                    end
                end
                ST_NEXT: begin
                    r_elem <= '0;
                    if (r_tok == TW'(SEQ_LEN - 1)) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_tok   <= r_tok + TW'(1);
                        r_state <= ST_IDLE;
                    end
                end
                ST_DONE: r_done <= 1'b1;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    ffn_mac_unit u_mac (
        .clk       (clk),
        .rst       (rst),
        .i_first   (w_first),
        .i_acc_en  (w_acc_en),
        .i_bias_en (w_bias_en),
        .i_x       (w_x),
        .i_w       (w_data),
        .o_data    (data_out),
        .o_valid   (data_out_valid)
    );

    assign w_addr = r_w_addr;
    assign done   = r_done;

endmodule

// File: doc/ffn_hidden_1.md
Name: ffn_hidden_1

Overview:
- First feed-forward (hidden-state-1) stage of the encoder, directly downstream of the second layer norm.
- Consumes the post-LN2 sequence of SEQ_LEN tokens, each streamed as D_MODEL serial Q8.8 elements.
- Per token, computes D_HID outputs: ReLU(W·x + b). Weights/bias come from an external synchronous ROM indexed by block_sel.
- Emits the D_HID results serially to the hidden-state-2 stage.

Parameters:
- DATA_W, 16, sample width (signed Q8.8)
- FRAC, 8, fractional bits
- SEQ_LEN, 30, tokens per sequence
- D_MODEL, 4, input elements per token
- D_HID, 8, hidden units per token
- ACC_W, 40, accumulator width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- data_in  in  16  token element, signed Q8.8
- data_in_valid  in  1  element strobe
- data_in_ready  out  1  block can accept an element
- block_sel  in  3  encoder block / weight-set select
- w_addr  out  3+clog2(D_HID)+clog2(D_MODEL+1)  ROM address = {block_sel_q, h, k}; k==D_MODEL selects bias
- w_data  in  16  ROM data, signed Q8.8, valid the cycle after w_addr
- data_out  out  16  hidden activation, Q8.8, non-negative
- data_out_valid  out  1  one-cycle strobe per hidden output
- done  out  1  sticky: full sequence processed

Behaviour:
- Interface: one clock (clk); synchronous active-high reset (rst).
- Reset: all outputs 0 except data_in_ready = 1. State = IDLE; token, element and unit counters = 0; token buffer cleared.
- Reset mid-operation: abort immediately; no further outputs.
- FSM:
  - IDLE: on an accepted element (valid && ready), store it in x[0], latch block_sel into block_sel_q, go to LOAD.
  - LOAD: store elements in x[1..D_MODEL-1]; after the last element, go to MAC.
  - MAC: per unit h, D_MODEL+2 cycles:
    - cycles 0..D_MODEL issue k = 0..D_MODEL;
    - data returns one cycle later;
    - acc += x[k]*w_data for k < D_MODEL;
    - acc += w_data <<< FRAC for bias.
    - data_out_valid is registered at cycle D_MODEL+2 relative to the first address.
    - The next unit's first address is issued in that same cycle.
    - After unit D_HID-1 is emitted, go to NEXT.
  - NEXT: if token == SEQ_LEN-1, go to DONE; else token++ and go to IDLE.
  - DONE: done = 1, data_in_ready = 0, hold until rst.
- data_in_ready = 1 only in IDLE/LOAD. Valid while not ready is ignored (no buffering).
- block_sel is sampled only on the first element of token 0 and ignored afterwards.
- Arithmetic:
  - 16×16 signed product at full 32 bits (Q16.16).
  - ACC_W signed accumulation, cleared at the start of each unit.
  - Result = acc >>> FRAC (arithmetic shift, truncation toward −inf).
  - Negative → 0x0000 (ReLU); > 0x7FFF → 0x7FFF.
- w_addr holds its last value when not issuing. data_out holds its last value between strobes.
- Latency: last element of a token accepted at cycle c → first data_out_valid at c+D_MODEL+3; subsequent outputs every D_MODEL+2 cycles.
- Throughput: data_in_ready returns 1 two cycles after the last unit's strobe (NEXT → IDLE).

Decomposition:
- Shared encoder package holds DATA_W, FRAC, SEQ_LEN, the Q8.8 saturate/ReLU function, and the FSM state enum (IDLE, LOAD, MAC, NEXT, DONE).
- One natural sub-module: ffn_mac_unit (accumulator, bias alignment, shift/ReLU/saturate, output register). Top holds the FSM, counters, token buffer and address generation.
- The ROM stays external (shared with hidden-state-2 tables).

Test Plan:
- Reset: assert rst 3 cycles → data_out_valid = 0, done = 0, data_out = 0, data_in_ready = 1 in the cycle after release.
- Identity: W[h][k] = 0x0100 if k == h%4 else 0, bias 0; x = (0x0100, 0x0200, 0xFF00, 0x0080) → outputs 0x0100, 0x0200, 0x0000, 0x0080, repeated twice (8 strobes).
- Saturation/bias: all W = 0x7FFF, x = 0x7FFF, bias = 0x7FFF → every output 0x7FFF. Bias = 0x8000 with zero weights → 0x0000.
- Latency/handshake: last element accepted at cycle c:
  - strobes at c+7, c+13, …, c+49;
  - data_in_ready low from c+1 through c+50, high at c+51;
  - valid pulses while not ready are ignored and the token buffer is unchanged.
- Full sequence: 30 tokens → exactly 240 strobes. done rises the cycle after NEXT of token 29. Further data_in_valid produces no output.
- block_sel/reset:
  - change block_sel from 2 to 5 after token 0 → w_addr[top 3 bits] stays 2 for all tokens;
  - assert rst during MAC of token 3 → no strobes after reset; a new sequence restarts at token 0 with the fresh block_sel.
